cmd_ctrl: RTL and testbench

//  Command controller between the SPI receiver and the VGA pipeline: it decodes each completed SPI frame
//  (command, databyte1, databyte2) into game state, score and tile-memory writes.

---
 rtl/cmd_ctrl.sv | 116 +++++++++++
 tb/tb_cmd_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cmd_ctrl.sv
// Command controller: decodes completed SPI frames into game state, score and tile-memory writes,
// with frame-synchronised outputs, a hardware memory-clear sweep and overrun accounting.
module cmd_ctrl #(
  parameter int unsigned STATE_W     = 16,
  parameter int unsigned SCORE_W     = 10,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DATA_W      = 3,
  parameter int unsigned DEPTH       = 600,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FRAME_SYNC  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cs,
  input  logic [7:0]         command,
  input  logic [7:0]         databyte1,
  input  logic [7:0]         databyte2,
  input  logic               frame_start,
  output logic [STATE_W-1:0] state,
  output logic [SCORE_W-1:0] score,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_waddr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic               busy,
  output logic [7:0]         overrun_cnt
);

  typedef enum logic {StIdle, StClear} fsm_e;

  localparam logic [3:0] OpSetState = 4'h1;
  localparam logic [3:0] OpSetScore = 4'h2;
  localparam logic [3:0] OpAddScore = 4'h3;
  localparam logic [3:0] OpWrTile   = 4'h4;
  localparam logic [3:0] OpClearMem = 4'h5;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  fsm_e                 fsm;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                 cs_prev;
  logic                 frame_rise;
  logic [STATE_W-1:0]   state_sh;
  logic [SCORE_W-1:0]   score_sh;
  logic [SCORE_W:0]     score_sum;
  logic [SCORE_W-1:0]   score_add;

  assign frame_rise = cs_sync[SYNC_STAGES-1] & ~cs_prev;

  // One extra bit catches the carry so the add can saturate instead of wrapping.
  assign score_sum = {1'b0, score_sh} + (SCORE_W + 1)'(databyte2);
  assign score_add = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm         <= StIdle;
      cs_sync     <= '0;
      cs_prev     <= 1'b0;
      state_sh    <= '0;
      score_sh    <= '0;
      state       <= '0;
      score       <= '0;
      mem_we      <= 1'b0;
      mem_waddr   <= '0;
      mem_wdata   <= '0;
      busy        <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      cs_sync <= {cs_sync[SYNC_STAGES-2:0], cs};
      cs_prev <= cs_sync[SYNC_STAGES-1];
      mem_we  <= 1'b0;

      // Nonblocking reads give the pre-update shadow when a command lands on frame_start.
      if (FRAME_SYNC == 0 || frame_start) begin
        state <= state_sh;
        score <= score_sh;
      end

      case (fsm)
        StIdle: begin
          if (frame_rise) begin
            case (command[7:4])
              OpSetState: state_sh <= STATE_W'({databyte1, databyte2});
              OpSetScore: score_sh <= SCORE_W'({databyte1, databyte2});
              OpAddScore: score_sh <= score_add;
              OpWrTile: begin
                mem_we    <= 1'b1;
                mem_waddr <= ADDR_W'({command[3:0], databyte1});
                mem_wdata <= DATA_W'(databyte2);
              end
              OpClearMem: begin
                fsm       <= StClear;
                busy      <= 1'b1;
                mem_we    <= 1'b1;
                mem_waddr <= '0;
                mem_wdata <= DATA_W'(databyte2);
              end
              default: ;
            endcase
          end
        end
        StClear: begin
          if (mem_waddr == LastAddr) begin
            fsm  <= StIdle;
            busy <= 1'b0;
          end else begin
            mem_we    <= 1'b1;
            mem_waddr <= mem_waddr + ADDR_W'(1);
          end
          if (frame_rise && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
        end
        default: fsm <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_ctrl.sv
// Directed bench for cmd_ctrl: one frame-synchronised instance and one immediate-update instance
// share all stimulus.
module tb_cmd_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cs;
  logic [7:0] command, databyte1, databyte2;
  logic       frame_start;

  logic [15:0] state_1, state_0;
  logic [9:0]  score_1, score_0;
  logic        we_1, we_0, busy_1, busy_0;
  logic [9:0]  waddr_1, waddr_0;
  logic [2:0]  wdata_1, wdata_0;
  logic [7:0]  ovr_1, ovr_0;

  int n_cmp = 0;
  int n_bad = 0;
  int we_count = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (we_1 === 1'b1) we_count++;

  cmd_ctrl #(.FRAME_SYNC(1)) dut (
    .clk(clk), .reset(reset), .cs(cs), .command(command), .databyte1(databyte1),
    .databyte2(databyte2), .frame_start(frame_start), .state(state_1), .score(score_1),
    .mem_we(we_1), .mem_waddr(waddr_1), .mem_wdata(wdata_1), .busy(busy_1), .overrun_cnt(ovr_1)
  );

  cmd_ctrl #(.FRAME_SYNC(0)) dut0 (
    .clk(clk), .reset(reset), .cs(cs), .command(command), .databyte1(databyte1),
    .databyte2(databyte2), .frame_start(frame_start), .state(state_0), .score(score_0),
    .mem_we(we_0), .mem_waddr(waddr_0), .mem_wdata(wdata_0), .busy(busy_0), .overrun_cnt(ovr_0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns in cycle E+1 of the frame; cs is already low again.
  task automatic frame(input logic [7:0] c, input logic [7:0] b1, input logic [7:0] b2);
    command = c; databyte1 = b1; databyte2 = b2;
    cs = 1'b1;
    tick();
    cs = 1'b0;
    tick();
    tick();
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_1 !== 1'b0 && n < 1000) begin
      tick();
      n++;
    end
    n_cmp++;
    if (busy_1 !== 1'b0) begin
      n_bad++; $display("FAIL wait_idle: busy=%b after %0d cycles, want 0", busy_1, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cs = 1'b0; frame_start = 1'b0;
    command = 8'h00; databyte1 = 8'h00; databyte2 = 8'h00;
    tick(); tick();
    n_cmp++; if (state_1 !== 16'h0) begin n_bad++; $display("FAIL rst_state: got %h want 0", state_1); end
    n_cmp++; if (score_1 !== 10'h0) begin n_bad++; $display("FAIL rst_score: got %h want 0", score_1); end
    n_cmp++; if (we_1 !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b want 0", we_1); end
    n_cmp++; if (busy_1 !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy_1); end
    n_cmp++; if (ovr_1 !== 8'h0) begin n_bad++; $display("FAIL rst_ovr: got %h want 0", ovr_1); end
    reset = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_write_tile();
    frame(8'h42, 8'h35, 8'h05);
    n_cmp++; if (we_1 !== 1'b1) begin n_bad++; $display("FAIL wt_we: got %b want 1", we_1); end
    n_cmp++; if (waddr_1 !== 10'h235) begin n_bad++; $display("FAIL wt_addr: got %h want 235", waddr_1); end
    n_cmp++; if (wdata_1 !== 3'b101) begin n_bad++; $display("FAIL wt_data: got %b want 101", wdata_1); end
    tick();
    n_cmp++; if (we_1 !== 1'b0) begin n_bad++; $display("FAIL wt_we_end: got %b want 0", we_1); end
    n_cmp++; if (busy_1 !== 1'b0) begin n_bad++; $display("FAIL wt_busy: got %b want 0", busy_1); end
  endtask

  task automatic test_score();
    frame(8'h20, 8'h01, 8'h00);
    frame(8'h30, 8'h00, 8'h05);
    tick();
    n_cmp++; if (score_0 !== 10'h105) begin n_bad++; $display("FAIL sc_add: got %h want 105", score_0); end
    frame(8'h20, 8'h03, 8'hF0);
    tick();
    n_cmp++; if (score_0 !== 10'h3F0) begin n_bad++; $display("FAIL sc_set: got %h want 3f0", score_0); end
    frame(8'h30, 8'h00, 8'h20);
    tick();
    n_cmp++; if (score_0 !== 10'h3FF) begin n_bad++; $display("FAIL sc_sat: got %h want 3ff", score_0); end
    frame(8'h7A, 8'h55, 8'h66);
    tick();
    n_cmp++; if (score_0 !== 10'h3FF) begin n_bad++; $display("FAIL sc_ignored: got %h want 3ff", score_0); end
    n_cmp++; if (we_1 !== 1'b0) begin n_bad++; $display("FAIL ign_we: got %b want 0", we_1); end
    n_cmp++; if (score_1 !== 10'h0) begin n_bad++; $display("FAIL sc_sync_hold: got %h want 0", score_1); end
    pulse_frame_start();
    n_cmp++; if (score_1 !== 10'h3FF) begin n_bad++; $display("FAIL sc_sync_upd: got %h want 3ff", score_1); end
  endtask

  task automatic test_clear();
    int base;
    base = we_count;
    frame(8'h50, 8'h00, 8'h07);
    for (int i = 0; i < 600; i++) begin
      n_cmp++;
      if (we_1 !== 1'b1 || busy_1 !== 1'b1 || waddr_1 !== 10'(i) || wdata_1 !== 3'd7) begin
        n_bad++;
        $display("FAIL clr_word%0d: we=%b busy=%b addr=%0d data=%0d want we=1 busy=1 addr=%0d data=7",
                 i, we_1, busy_1, waddr_1, wdata_1, i);
      end
      tick();
    end
    n_cmp++; if (busy_1 !== 1'b0) begin n_bad++; $display("FAIL clr_busy_end: got %b want 0", busy_1); end
    n_cmp++; if (we_1 !== 1'b0) begin n_bad++; $display("FAIL clr_we_end: got %b want 0", we_1); end
    n_cmp++; if (we_count - base !== 600) begin n_bad++; $display("FAIL clr_count: got %0d want 600", we_count - base); end
  endtask

  task automatic test_overrun();
    int base;
    base = we_count;
    frame(8'h50, 8'h00, 8'h01);
    for (int i = 0; i < 3; i++) frame(8'h42, 8'h35, 8'h05);
    wait_idle();
    n_cmp++; if (ovr_1 !== 8'd3) begin n_bad++; $display("FAIL ovr_3: got %0d want 3", ovr_1); end
    n_cmp++; if (we_count - base !== 600) begin n_bad++; $display("FAIL ovr_writes: got %0d want 600", we_count - base); end
  endtask

  task automatic test_busy_edge();
    // Frame landing on the last sweep cycle is dropped.
    frame(8'h50, 8'h00, 8'h02);
    repeat (597) tick();
    frame(8'h41, 8'h10, 8'h03);
    n_cmp++; if (ovr_1 !== 8'd4) begin n_bad++; $display("FAIL edge_drop_ovr: got %0d want 4", ovr_1); end
    n_cmp++; if (we_1 !== 1'b0) begin n_bad++; $display("FAIL edge_drop_we: got %b want 0", we_1); end
    wait_idle();
    // Frame landing on the cycle busy falls is executed.
    frame(8'h50, 8'h00, 8'h02);
    repeat (598) tick();
    frame(8'h41, 8'h10, 8'h03);
    n_cmp++; if (we_1 !== 1'b1) begin n_bad++; $display("FAIL edge_acc_we: got %b want 1", we_1); end
    n_cmp++; if (waddr_1 !== 10'h110) begin n_bad++; $display("FAIL edge_acc_addr: got %h want 110", waddr_1); end
    n_cmp++; if (wdata_1 !== 3'd3) begin n_bad++; $display("FAIL edge_acc_data: got %0d want 3", wdata_1); end
    n_cmp++; if (ovr_1 !== 8'd4) begin n_bad++; $display("FAIL edge_acc_ovr: got %0d want 4", ovr_1); end
    tick();
  endtask

  task automatic test_saturation();
    for (int r = 0; r < 3; r++) begin
      frame(8'h50, 8'h00, 8'h00);
      for (int i = 0; i < 100; i++) frame(8'h42, 8'h35, 8'h05);
      wait_idle();
      if (r == 0) begin
        n_cmp++; if (ovr_1 !== 8'd104) begin n_bad++; $display("FAIL ovr_104: got %0d want 104", ovr_1); end
      end
    end
    n_cmp++; if (ovr_1 !== 8'd255) begin n_bad++; $display("FAIL ovr_sat: got %0d want 255", ovr_1); end
  endtask

  task automatic test_state_nosync();
    frame(8'h10, 8'h12, 8'h34);
    n_cmp++; if (state_0 !== 16'h0) begin n_bad++; $display("FAIL st_e1: got %h want 0", state_0); end
    tick();
    n_cmp++; if (state_0 !== 16'h1234) begin n_bad++; $display("FAIL st_e2: got %h want 1234", state_0); end
    n_cmp++; if (state_1 !== 16'h0) begin n_bad++; $display("FAIL st_sync_hold: got %h want 0", state_1); end
    pulse_frame_start();
    n_cmp++; if (state_1 !== 16'h1234) begin n_bad++; $display("FAIL st_sync_upd: got %h want 1234", state_1); end
  endtask

  task automatic test_reset_mid_clear();
    int base;
    frame(8'h50, 8'h00, 8'h06);
    repeat (100) tick();
    n_cmp++; if (busy_1 !== 1'b1) begin n_bad++; $display("FAIL mid_busy: got %b want 1", busy_1); end
    reset = 1'b1;
    #1;
    n_cmp++; if (busy_1 !== 1'b0) begin n_bad++; $display("FAIL mr_busy: got %b want 0", busy_1); end
    n_cmp++; if (we_1 !== 1'b0) begin n_bad++; $display("FAIL mr_we: got %b want 0", we_1); end
    n_cmp++; if (state_1 !== 16'h0) begin n_bad++; $display("FAIL mr_state: got %h want 0", state_1); end
    n_cmp++; if (score_1 !== 10'h0) begin n_bad++; $display("FAIL mr_score: got %h want 0", score_1); end
    n_cmp++; if (ovr_1 !== 8'h0) begin n_bad++; $display("FAIL mr_ovr: got %h want 0", ovr_1); end
    tick(); tick();
    reset = 1'b0;
    base = we_count;
    repeat (50) tick();
    n_cmp++; if (we_count - base !== 0) begin n_bad++; $display("FAIL mr_writes: got %0d want 0", we_count - base); end
    n_cmp++; if (busy_1 !== 1'b0) begin n_bad++; $display("FAIL mr_busy_after: got %b want 0", busy_1); end
  endtask

  initial begin
    test_reset();
    test_write_tile();
    test_score();
    test_clear();
    test_overrun();
    test_busy_edge();
    test_saturation();
    test_state_nosync();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
